imem_loader: RTL

Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first. It writes them into a writable instruction memory at word addresses 0..N-1, using the same 4-bit word indexing as the fetch path (pc[4:1]). While loading, it holds the CPU so the program is not executed until the load is complete.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 33 +++
 rtl/imem_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// Used by the loader, its bus interface and the fetch-side memories.
// No logic here: types and sizes only.
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 16;
    localparam int IMEM_ADDR_W = 4;
    localparam int IMEM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        WRITE,
        DONE
    } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: control pulses, byte stream in, word write strobe out.
// Combinational bundle only, no latency of its own.
// Byte stream uses valid/ready; the write strobe has no backpressure.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);

    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    // master drives the byte stream and watches the memory side
    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

endinterface

// File: rtl/imem_loader.sv
// Assembles a byte stream (count, then hi/lo pairs) into instruction-memory word writes.
// Latency: last lo byte at edge t -> wr_en in cycle t+1 -> done in cycle t+2; 3+ cycles per word.
// Backpressure: in_ready drops in IDLE/WRITE/DONE; in_valid gaps stall the FSM indefinitely.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    imem_loader_if.slave bus
);

    localparam logic [7:0]    DEPTH_B   = 8'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

    ld_state_t         state;
    logic [7:0]        hi_byte;
    logic [ADDR_W:0]   count;      // one extra bit so count == DEPTH fits
    logic [ADDR_W-1:0] index;
    logic              accept;
    logic              last_word;

    assign bus.in_ready = (state == COUNT) || (state == HI) || (state == LO);
    assign accept       = bus.in_valid & bus.in_ready;
    assign last_word    = ({1'b0, index} == (count - COUNT_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hi_byte      <= '0;
            count        <= '0;
            index        <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.cpu_hold <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= COUNT;
                        bus.cpu_hold <= 1'b1;
                        bus.error    <= 1'b0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if ((bus.in_data != 8'd0) && (bus.in_data <= DEPTH_B)) begin
                            count <= bus.in_data[ADDR_W:0];
                            index <= '0;
                            state <= HI;
                        end else begin
                            // CPU stays held until a good load or reset
                            bus.error <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                HI: begin
                    if (accept) begin
                        hi_byte <= bus.in_data;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= index;
                        bus.wr_data <= DATA_W'({hi_byte, bus.in_data});
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        bus.done     <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                        state        <= DONE;
                    end else begin
                        index <= index + ADDR_W'(1);
                        state <= HI;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
